// File: rtl/vx_operands_lane_splitter_if.sv
// Operand bundle types and the valid/ready interface that carries a bundle
// from the operand collector to the lane splitter.
package vx_operands_lane_splitter_pkg;

  localparam int unsigned NUM_THREADS = 4;
  localparam int unsigned XLEN        = 32;

  typedef struct packed {
    logic [7:0]  uuid;
    logic [1:0]  wid;
    logic [31:0] pc;
    logic [3:0]  op_type;
    logic        wb;
    logic [4:0]  rd;
  } op_hdr_t;

  localparam int unsigned HDR_W = $bits(op_hdr_t);

  typedef logic [NUM_THREADS-1:0][XLEN-1:0] lane_data_t;

  typedef struct packed {
    op_hdr_t                hdr;
    logic [NUM_THREADS-1:0] tmask;
    lane_data_t             rs1_data;
    lane_data_t             rs2_data;
    lane_data_t             rs3_data;
  } operands_t;

endpackage

interface vx_operands_if;
  import vx_operands_lane_splitter_pkg::*;

  logic      valid;
  operands_t data;
  logic      ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/vx_operands_lane_splitter.sv
// Splits one operand bundle into OUT_LANES-wide beats, emitting only packets
// with at least one active thread (a single empty beat for an all-zero mask).
module vx_operands_lane_splitter
  import vx_operands_lane_splitter_pkg::*;
#(
  parameter int unsigned  NUM_LANES  = NUM_THREADS,
  parameter int unsigned  OUT_LANES  = 2,
  localparam int unsigned NUM_PKTS   = NUM_LANES / OUT_LANES,
  localparam int unsigned PID_W      = (NUM_PKTS > 1) ? $clog2(NUM_PKTS) : 1,
  localparam int unsigned LANE_IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  vx_operands_if.slave              operands_if,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [HDR_W-1:0]          out_header,
  output logic [OUT_LANES-1:0]      out_tmask,
  output logic [OUT_LANES*XLEN-1:0] out_rs1_data,
  output logic [OUT_LANES*XLEN-1:0] out_rs2_data,
  output logic [OUT_LANES*XLEN-1:0] out_rs3_data,
  output logic [PID_W-1:0]          out_pid,
  output logic                      out_sop,
  output logic                      out_eop
);

  if (((NUM_LANES % OUT_LANES) != 0) || (NUM_LANES != NUM_THREADS)) begin : g_cfg_check
    $error("vx_operands_lane_splitter: NUM_LANES must match NUM_THREADS and be a multiple of OUT_LANES");
  end

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic                   ready_c;
  logic                   load_new;
  logic                   advance;

  logic [NUM_LANES-1:0]   tmask_q;
  lane_data_t             rs1_q, rs2_q, rs3_q;

  logic [NUM_LANES-1:0]   src_tmask;
  lane_data_t             src_rs1, src_rs2, src_rs3;
  logic [NUM_PKTS-1:0]    act;
  int unsigned            start;
  logic                   found;
  logic [PID_W-1:0]       pid_n;
  logic                   eop_n;
  logic [LANE_IDX_W-1:0]  base_n;

  assign operands_if.ready = ready_c;

  // Handshake control: accept in IDLE, or on the edge the last beat retires.
  always_comb begin
    state_d  = state_q;
    ready_c  = 1'b0;
    load_new = 1'b0;
    advance  = 1'b0;
    case (state_q)
      IDLE: begin
        ready_c = 1'b1;
        if (operands_if.valid) begin
          load_new = 1'b1;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (out_eop) begin
            ready_c = 1'b1;
            if (operands_if.valid) begin
              load_new = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            advance = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (!reset) begin
      state_d  = IDLE;
      ready_c  = 1'b0;
      load_new = 1'b0;
      advance  = 1'b0;
    end
  end

  // Next beat selection: search from packet 0 for a new bundle, else past the current pid.
  always_comb begin
    src_tmask = tmask_q;
    src_rs1   = rs1_q;
    src_rs2   = rs2_q;
    src_rs3   = rs3_q;
    start     = 32'(out_pid) + 32'd1;
    if (load_new) begin
      src_tmask = operands_if.data.tmask;
      src_rs1   = operands_if.data.rs1_data;
      src_rs2   = operands_if.data.rs2_data;
      src_rs3   = operands_if.data.rs3_data;
      start     = 32'd0;
    end

    for (int unsigned p = 0; p < NUM_PKTS; p++) begin
      act[p] = |src_tmask[p*OUT_LANES +: OUT_LANES];
    end

    pid_n = '0;
    found = 1'b0;
    for (int unsigned p = 0; p < NUM_PKTS; p++) begin
      if (!found && (p >= start) && act[p]) begin
        pid_n = PID_W'(p);
        found = 1'b1;
      end
    end

    eop_n = 1'b1;
    for (int unsigned p = 0; p < NUM_PKTS; p++) begin
      if ((p > 32'(pid_n)) && act[p]) begin
        eop_n = 1'b0;
      end
    end

    base_n = LANE_IDX_W'(32'(pid_n) * OUT_LANES);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_pid   <= '0;
      tmask_q   <= '0;
    end else begin
      state_q   <= state_d;
      out_valid <= (state_d == SEND);
      if (load_new) begin
        tmask_q <= operands_if.data.tmask;
      end
      if (load_new || advance) begin
        out_sop <= load_new;
        out_eop <= eop_n;
        out_pid <= pid_n;
      end
    end
  end

  // Payload registers carry no reset; they are only observed while out_valid is high.
  always_ff @(posedge clk) begin
    if (load_new) begin
      rs1_q      <= operands_if.data.rs1_data;
      rs2_q      <= operands_if.data.rs2_data;
      rs3_q      <= operands_if.data.rs3_data;
      out_header <= operands_if.data.hdr;
    end
    if (load_new || advance) begin
      out_tmask    <= src_tmask[base_n +: OUT_LANES];
      out_rs1_data <= src_rs1[base_n +: OUT_LANES];
      out_rs2_data <= src_rs2[base_n +: OUT_LANES];
      out_rs3_data <= src_rs3[base_n +: OUT_LANES];
    end
  end

endmodule

// File: tb/tb_vx_operands_lane_splitter.sv
// Bench for the operand lane splitter: directed scenarios plus a randomized
// scoreboard run against a packet-list model of the expected beat stream.
module tb_vx_operands_lane_splitter;
  import vx_operands_lane_splitter_pkg::*;

  localparam int unsigned NL = NUM_THREADS;
  localparam int unsigned OL = 2;
  localparam int unsigned NP = NL / OL;

  logic              clk;
  logic              reset;
  logic              out_ready;
  logic              out_valid;
  logic [HDR_W-1:0]  out_header;
  logic [OL-1:0]     out_tmask;
  logic [OL*XLEN-1:0] out_rs1_data, out_rs2_data, out_rs3_data;
  logic [0:0]        out_pid;
  logic              out_sop, out_eop;

  vx_operands_if op_if ();

  vx_operands_lane_splitter #(.NUM_LANES(NL), .OUT_LANES(OL)) dut (
    .clk          (clk),
    .reset        (reset),
    .operands_if  (op_if),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_header   (out_header),
    .out_tmask    (out_tmask),
    .out_rs1_data (out_rs1_data),
    .out_rs2_data (out_rs2_data),
    .out_rs3_data (out_rs3_data),
    .out_pid      (out_pid),
    .out_sop      (out_sop),
    .out_eop      (out_eop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [HDR_W-1:0]   hdr;
    logic [0:0]         pid;
    logic [OL-1:0]      tmask;
    logic [OL*XLEN-1:0] rs1;
    logic [OL*XLEN-1:0] rs2;
    logic [OL*XLEN-1:0] rs3;
    logic               sop;
    logic               eop;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;

  logic  s_ready, s_valid;
  beat_t s_beat;

  // Expected beats: one per packet holding an active thread, in packet order.
  function automatic void model_push(input operands_t d);
    int    act[$];
    beat_t b;
    for (int p = 0; p < int'(NP); p++) begin
      int n = 0;
      for (int k = 0; k < int'(OL); k++) n += int'(d.tmask[p*OL+k]);
      if (n > 0) act.push_back(p);
    end
    if (act.size() == 0) act.push_back(0);
    for (int i = 0; i < act.size(); i++) begin
      int p = act[i];
      b.hdr = d.hdr;
      b.pid = 1'(p);
      for (int k = 0; k < int'(OL); k++) begin
        b.tmask[k] = d.tmask[p*OL+k];
        b.rs1[k*XLEN +: XLEN] = d.rs1_data[p*OL+k];
        b.rs2[k*XLEN +: XLEN] = d.rs2_data[p*OL+k];
        b.rs3[k*XLEN +: XLEN] = d.rs3_data[p*OL+k];
      end
      b.sop = (i == 0);
      b.eop = (i == act.size() - 1);
      exp_q.push_back(b);
    end
  endfunction

  function automatic operands_t rand_ops(input logic [NL-1:0] tm);
    operands_t   d;
    logic [63:0] r;
    r       = {$urandom(), $urandom()};
    d.hdr   = r[HDR_W-1:0];
    d.tmask = tm;
    for (int l = 0; l < int'(NL); l++) begin
      d.rs1_data[l] = $urandom();
      d.rs2_data[l] = $urandom();
      d.rs3_data[l] = $urandom();
    end
    return d;
  endfunction

  // Drive at the falling edge, sample 1ns before the rising edge, then advance one cycle.
  task automatic step(input logic v, input operands_t d, input logic ordy);
    op_if.valid = v;
    op_if.data  = d;
    out_ready   = ordy;
    #4;
    s_ready      = op_if.ready;
    s_valid      = out_valid;
    s_beat.hdr   = out_header;
    s_beat.pid   = out_pid;
    s_beat.tmask = out_tmask;
    s_beat.rs1   = out_rs1_data;
    s_beat.rs2   = out_rs2_data;
    s_beat.rs3   = out_rs3_data;
    s_beat.sop   = out_sop;
    s_beat.eop   = out_eop;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    operands_t d;
    d = rand_ops(4'b1111);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, d, 1'b1);
      checks++;
      if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", s_ready); end
      checks++;
      if ({s_valid, s_beat.sop, s_beat.eop, s_beat.pid} !== 4'b0000) begin
        errors++; $display("FAIL reset_outs: got valid/sop/eop/pid %b expected 0000", {s_valid, s_beat.sop, s_beat.eop, s_beat.pid});
      end
    end
    reset = 1'b1;
    step(1'b0, d, 1'b1);
    checks++;
    if ({s_ready, s_valid} !== 2'b10) begin errors++; $display("FAIL reset_release: got ready/valid %b expected 10", {s_ready, s_valid}); end
  endtask

  task automatic test_full_mask();
    operands_t d;
    beat_t     e;
    d = rand_ops(4'b1111);
    exp_q.delete();
    step(1'b1, d, 1'b1);
    model_push(d);
    step(1'b0, d, 1'b1);
    e = exp_q.pop_front();
    checks++;
    if (!s_valid || s_beat !== e) begin errors++; $display("FAIL full_beat0: got v=%b %h expected %h", s_valid, s_beat, e); end
    checks++;
    if ({s_ready, s_beat.pid, s_beat.sop, s_beat.eop, s_beat.tmask} !== 6'b0_0_1_0_11) begin
      errors++; $display("FAIL full_beat0_ctl: got ready/pid/sop/eop/tmask %b expected 001011", {s_ready, s_beat.pid, s_beat.sop, s_beat.eop, s_beat.tmask});
    end
    step(1'b0, d, 1'b1);
    e = exp_q.pop_front();
    checks++;
    if (!s_valid || s_beat !== e) begin errors++; $display("FAIL full_beat1: got v=%b %h expected %h", s_valid, s_beat, e); end
    checks++;
    if ({s_ready, s_beat.pid, s_beat.sop, s_beat.eop, s_beat.tmask} !== 6'b1_1_0_1_11) begin
      errors++; $display("FAIL full_beat1_ctl: got ready/pid/sop/eop/tmask %b expected 110111", {s_ready, s_beat.pid, s_beat.sop, s_beat.eop, s_beat.tmask});
    end
    step(1'b0, d, 1'b1);
    checks++;
    if (s_valid !== 1'b0) begin errors++; $display("FAIL full_idle: got valid %b expected 0", s_valid); end
  endtask

  task automatic test_sparse();
    logic [NL-1:0] masks[2];
    logic [4:0]    ctl[2];
    operands_t     d;
    beat_t         e;
    masks[0] = 4'b1100; ctl[0] = 5'b1_1_1_11;
    masks[1] = 4'b0000; ctl[1] = 5'b0_1_1_00;
    for (int i = 0; i < 2; i++) begin
      d = rand_ops(masks[i]);
      exp_q.delete();
      step(1'b1, d, 1'b1);
      model_push(d);
      step(1'b0, d, 1'b1);
      e = exp_q.pop_front();
      checks++;
      if (!s_valid || s_beat !== e) begin errors++; $display("FAIL sparse%0d_beat: got v=%b %h expected %h", i, s_valid, s_beat, e); end
      checks++;
      if ({s_beat.pid, s_beat.sop, s_beat.eop, s_beat.tmask} !== ctl[i]) begin
        errors++; $display("FAIL sparse%0d_ctl: got pid/sop/eop/tmask %b expected %b", i, {s_beat.pid, s_beat.sop, s_beat.eop, s_beat.tmask}, ctl[i]);
      end
      step(1'b0, d, 1'b1);
      checks++;
      if (s_valid !== 1'b0) begin errors++; $display("FAIL sparse%0d_single: got valid %b expected 0", i, s_valid); end
    end
  endtask

  task automatic test_stall();
    operands_t d;
    beat_t     e0, e1;
    d = rand_ops(4'b1111);
    exp_q.delete();
    step(1'b1, d, 1'b1);
    model_push(d);
    e0 = exp_q.pop_front();
    e1 = exp_q.pop_front();
    for (int c = 0; c < 4; c++) begin
      step(1'b0, d, (c == 3));
      checks++;
      if (!s_valid || s_beat !== e0 || s_ready !== 1'b0) begin
        errors++; $display("FAIL stall_hold%0d: got v=%b r=%b %h expected %h", c, s_valid, s_ready, s_beat, e0);
      end
    end
    step(1'b0, d, 1'b1);
    checks++;
    if (!s_valid || s_beat !== e1) begin errors++; $display("FAIL stall_next: got v=%b %h expected %h", s_valid, s_beat, e1); end
    step(1'b0, d, 1'b1);
    checks++;
    if (s_valid !== 1'b0) begin errors++; $display("FAIL stall_dup: got valid %b expected 0", s_valid); end
  endtask

  task automatic test_back_to_back();
    operands_t a, b;
    beat_t     e;
    a = rand_ops(4'b1111);
    b = rand_ops(4'b1111);
    exp_q.delete();
    step(1'b1, a, 1'b1);
    model_push(a);
    for (int i = 0; i < 4; i++) begin
      step((i < 2), b, 1'b1);
      if (i == 1) model_push(b);
      e = exp_q.pop_front();
      checks++;
      if (!s_valid || s_beat !== e) begin errors++; $display("FAIL b2b_beat%0d: got v=%b %h expected %h", i, s_valid, s_beat, e); end
      if (i >= 2) begin
        checks++;
        if (s_beat.hdr !== b.hdr) begin errors++; $display("FAIL b2b_hdr%0d: got %h expected %h", i, s_beat.hdr, b.hdr); end
      end
    end
    step(1'b0, b, 1'b1);
    checks++;
    if (s_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle: got valid %b expected 0", s_valid); end
  endtask

  task automatic test_reset_mid();
    operands_t d;
    d = rand_ops(4'b1111);
    exp_q.delete();
    step(1'b1, d, 1'b1);
    step(1'b0, d, 1'b0);
    checks++;
    if (s_valid !== 1'b1) begin errors++; $display("FAIL rmid_stalled: got valid %b expected 1", s_valid); end
    reset = 1'b0;
    step(1'b0, d, 1'b0);
    checks++;
    if (s_ready !== 1'b0) begin errors++; $display("FAIL rmid_ready_low: got %b expected 0", s_ready); end
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step(1'b0, d, 1'b1);
      checks++;
      if (s_valid !== 1'b0 || s_ready !== 1'b1) begin
        errors++; $display("FAIL rmid_quiet%0d: got valid/ready %b expected 01", c, {s_valid, s_ready});
      end
    end
  endtask

  task automatic test_random();
    operands_t     d;
    logic [NL-1:0] tm;
    logic          v, ordy, exp_ready;
    exp_q.delete();
    for (int c = 0; c < 800; c++) begin
      v    = (c < 760) ? ($urandom_range(0, 2) != 0) : 1'b0;
      ordy = (c < 760) ? ($urandom_range(0, 3) != 0) : 1'b1;
      tm   = ($urandom_range(0, 4) == 0) ? 4'b0000 : NL'($urandom());
      d    = rand_ops(tm);
      exp_ready = (exp_q.size() == 0) || (ordy && exp_q.size() == 1);
      step(v, d, ordy);
      checks++;
      if (s_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready c%0d: got %b expected %b", c, s_ready, exp_ready); end
      if (exp_q.size() != 0) begin
        checks++;
        if (!s_valid || s_beat !== exp_q[0]) begin
          errors++; $display("FAIL rnd_beat c%0d: got v=%b %h expected %h", c, s_valid, s_beat, exp_q[0]);
        end
        if (ordy) void'(exp_q.pop_front());
      end else begin
        checks++;
        if (s_valid !== 1'b0) begin errors++; $display("FAIL rnd_spurious c%0d: got valid %b expected 0", c, s_valid); end
      end
      if (v && s_ready) model_push(d);
    end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL rnd_drain: got %0d beats pending expected 0", exp_q.size()); end
  endtask

  initial begin
    reset       = 1'b0;
    out_ready   = 1'b0;
    op_if.valid = 1'b0;
    op_if.data  = '0;
    @(negedge clk);
    test_reset();
    test_full_mask();
    test_sparse();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vx_operands_lane_splitter.md
VX_OPERANDS_LANE_SPLITTER -- requirements
Module: VX_operands_lane_splitter

Interface
REQ-001 Parameter NUM_LANES, default `NUM_THREADS`, input lane count carried in operands_t.
REQ-002 Parameter OUT_LANES, default 2, lanes per output beat; NUM_LANES % OUT_LANES == 0 SHALL be checked by static assertion.
REQ-003 Derived NUM_PKTS = NUM_LANES/OUT_LANES; PID_W = max(1, clog2(NUM_PKTS)).
REQ-004 clk  input  1  sole clock.
REQ-005 reset  input  1  synchronous, active-low (0 = reset), sampled on rising clk.
REQ-006 operands_if  VX_operands_if.slave  --  upstream bundle: valid in, data (operands_t) in, ready out.
REQ-007 out_valid  output  1  output beat valid.
REQ-008 out_ready  input  1  downstream accepts beat.
REQ-009 out_header  output  HDR_W  all operands_t fields except tmask and rs1/rs2/rs3_data, copied unchanged.
REQ-010 out_tmask  output  OUT_LANES  tmask slice for current packet.
REQ-011 out_rs1_data, out_rs2_data, out_rs3_data  output  OUT_LANES*`XLEN each  lane-data slices for current packet.
REQ-012 out_pid  output  PID_W  packet index (lanes pid*OUT_LANES .. pid*OUT_LANES+OUT_LANES-1).
REQ-013 out_sop, out_eop  output  1 each  first / last beat of the bundle.

Function
REQ-014 Block SHALL be the consumer end of the operand handshake: bundle transferred when valid && ready high on the same rising edge.
REQ-015 FSM states IDLE, SEND; one registered bundle buffer.
REQ-016 IDLE: operands_if.ready = 1; on transfer, capture bundle, compute first active packet, go SEND.
REQ-017 SEND: out_valid = 1; beat retired when out_valid && out_ready.
REQ-018 Active packet = any packet whose tmask slice is nonzero; inactive packets SHALL be skipped, never emitted.
REQ-019 First beat = lowest-index active packet, out_sop = 1; subsequent beats = next higher active index, out_sop = 0.
REQ-020 out_eop = 1 iff no higher-index active packet remains.
REQ-021 All-zero tmask: exactly one beat, out_pid = 0, out_tmask = 0, out_sop = out_eop = 1.
REQ-022 Latency: first beat out_valid asserted the cycle after input transfer; one beat per cycle while out_ready held high.
REQ-023 While out_valid && !out_ready, all out_* SHALL remain stable.
REQ-024 SEND: operands_if.ready = out_valid && out_ready && out_eop (combinational); if a new bundle transfers on that edge, stay SEND with new bundle, next cycle out_sop = 1, no bubble.
REQ-025 If eop retires with no incoming bundle, return to IDLE; out_valid = 0 next cycle.
REQ-026 out_header SHALL be identical on every beat of one bundle.
REQ-027 No combinational path from operands_if.valid/data to any out_* signal.
REQ-028 Upstream data SHALL NOT be read except on the transfer edge.

Reset
REQ-029 reset == 0: state = IDLE, out_valid = 0, out_sop = 0, out_eop = 0, out_pid = 0, buffer tmask = 0; operands_if.ready = 0 while reset low, 1 in the first cycle after release.
REQ-030 Reset mid-bundle SHALL discard remaining beats; no beat emitted after release until a new transfer.
REQ-031 Data payload registers need not be reset.

Verification
REQ-032 NUM_LANES=4, OUT_LANES=2, tmask=4'b1111, out_ready=1 -> pid 0 (sop, tmask 2'b11), then pid 1 (eop, tmask 2'b11); operands_if.ready = 1 only in the pid-1 cycle.
REQ-033 tmask=4'b1100 -> single beat pid 1, sop=eop=1, tmask 2'b11; tmask=4'b0000 -> single beat pid 0, tmask 2'b00, sop=eop=1.
REQ-034 tmask=4'b1111, out_ready low 3 cycles on pid 0 -> pid 0 outputs stable for 4 cycles, then pid 1; no beat lost or duplicated.
REQ-035 Two back-to-back bundles, upstream valid continuous, out_ready=1 -> 4 consecutive valid beats, no bubble; second bundle out_header on beats 3-4.
REQ-036 reset driven 0 while pid 0 stalled -> out_valid = 0 next cycle; after release, no output until a new bundle transfers; random-stimulus scoreboard: lanes out == active lanes in, in order.
